// File: rtl/sync_fifo_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sync_fifo_if                                           |
// | Description : Producer/consumer handshake bundle for sync_fifo.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface sync_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  write_en;
    logic                  read_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;

    // The user side of the FIFO: issues requests, observes data and status.
    modport master (
        output write_en,
        output read_en,
        output data_in,
        input  data_out,
        input  full,
        input  empty,
        input  almost_full,
        input  almost_empty,
        input  overflow,
        input  underflow
    );

    modport slave (
        input  write_en,
        input  read_en,
        input  data_in,
        output data_out,
        output full,
        output empty,
        output almost_full,
        output almost_empty,
        output overflow,
        output underflow
    );
endinterface : sync_fifo_if
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sync_fifo                                              |
// | Description : Single-clock FIFO, registered read port, status and    |
// |               error flags. Define FIFO_STICKY_ERR_EN to make         |
// |               overflow/underflow sticky until reset.                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,   // power of 2, >= 4
    parameter int ADDR_WIDTH = 4     // log2(DEPTH)
) (
    input  wire logic  clk,
    input  wire logic  reset_n,
    sync_fifo_if.slave bus
);

    localparam logic [ADDR_WIDTH:0]   c_COUNT_FULL   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   c_COUNT_AFULL  = (ADDR_WIDTH+1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   c_COUNT_ONE    = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   c_COUNT_ZERO   = '0;
    localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE      = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_ovf_evt;
    logic                  w_unf_evt;

    assign w_full    = (r_count == c_COUNT_FULL);
    assign w_empty   = (r_count == c_COUNT_ZERO);

    // A full FIFO still takes a write when a read frees a slot on the same edge.
    assign w_wr_acc  = bus.write_en && (!w_full || bus.read_en);
    assign w_rd_acc  = bus.read_en && !w_empty;
    assign w_ovf_evt = bus.write_en && w_full && !bus.read_en;
    assign w_unf_evt = bus.read_en && w_empty;

    always_ff @(posedge clk) begin
        if (reset_n && w_wr_acc) begin
            r_mem[r_wptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_data_out  <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rptr     <= r_rptr + c_PTR_ONE;
                r_data_out <= r_mem[r_rptr];
            end
            if (w_wr_acc && !w_rd_acc) begin
                r_count <= r_count + c_COUNT_ONE;
            end else if (w_rd_acc && !w_wr_acc) begin
                r_count <= r_count - c_COUNT_ONE;
            end
`ifdef FIFO_STICKY_ERR_EN
            r_overflow  <= r_overflow  | w_ovf_evt;
            r_underflow <= r_underflow | w_unf_evt;
`else
            r_overflow  <= w_ovf_evt;
            r_underflow <= w_unf_evt;
`endif
        end
    end

    assign bus.data_out     = r_data_out;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= c_COUNT_AFULL);
    assign bus.almost_empty = (r_count <= c_COUNT_ONE);
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

endmodule : sync_fifo
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_sync_fifo                                           |
// | Description : Self-checking bench for sync_fifo: queue-based model, |
// |               directed scenarios and randomized traffic.             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_sync_fifo;

    localparam int c_DW    = 8;
    localparam int c_DEPTH = 16;
    localparam int c_AW    = 4;

    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;
    bit   chk_en;

    sync_fifo_if #(.DATA_WIDTH(c_DW)) bus ();

    sync_fifo #(
        .DATA_WIDTH (c_DW),
        .DEPTH      (c_DEPTH),
        .ADDR_WIDTH (c_AW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: contents as a queue, outputs derived from its size.
    logic [c_DW-1:0] m_q [$];
    logic [c_DW-1:0] m_dout;
    logic            m_ovf;
    logic            m_unf;

    always @(posedge clk) begin
        bit m_full, m_empty, rd_ok, wr_ok, ovf_evt, unf_evt;
        if (!reset_n) begin
            m_q.delete();
            m_dout = '0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            m_full  = (m_q.size() == c_DEPTH);
            m_empty = (m_q.size() == 0);
            rd_ok   = bus.read_en && !m_empty;
            wr_ok   = bus.write_en && (!m_full || bus.read_en);
            ovf_evt = bus.write_en && m_full && !bus.read_en;
            unf_evt = bus.read_en && m_empty;
            if (rd_ok) m_dout = m_q.pop_front();
            if (wr_ok) m_q.push_back(bus.data_in);
`ifdef FIFO_STICKY_ERR_EN
            m_ovf = m_ovf | ovf_evt;
            m_unf = m_unf | unf_evt;
`else
            m_ovf = ovf_evt;
            m_unf = unf_evt;
`endif
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("data_out",     32'(bus.data_out),     32'(m_dout));
            check("full",         32'(bus.full),         32'(m_q.size() == c_DEPTH));
            check("empty",        32'(bus.empty),        32'(m_q.size() == 0));
            check("almost_full",  32'(bus.almost_full),  32'(m_q.size() >= c_DEPTH - 1));
            check("almost_empty", 32'(bus.almost_empty), 32'(m_q.size() <= 1));
            check("overflow",     32'(bus.overflow),     32'(m_ovf));
            check("underflow",    32'(bus.underflow),    32'(m_unf));
        end
    end

    task automatic step(input logic we, input logic re, input logic [c_DW-1:0] din);
        bus.write_en = we;
        bus.read_en  = re;
        bus.data_in  = din;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        chk_en      = 1'b0;
        reset_n     = 1'b0;
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        chk_en = 1'b1;
        check("rst_empty",        32'(bus.empty),        32'd1);
        check("rst_almost_empty", 32'(bus.almost_empty), 32'd1);
        check("rst_full",         32'(bus.full),         32'd0);
        check("rst_almost_full",  32'(bus.almost_full),  32'd0);
        check("rst_overflow",     32'(bus.overflow),     32'd0);
        check("rst_underflow",    32'(bus.underflow),    32'd0);
        check("rst_data_out",     32'(bus.data_out),     32'd0);
        reset_n = 1'b1;

        // Fill 0x00..0x0F
        for (int i = 0; i < c_DEPTH; i++) begin
            step(1'b1, 1'b0, c_DW'(i));
            if (i == c_DEPTH - 2) begin
                check("fill_afull_15", 32'(bus.almost_full), 32'd1);
                check("fill_full_15",  32'(bus.full),        32'd0);
            end
        end
        check("fill_full_16", 32'(bus.full), 32'd1);

        // Overflow while full
        step(1'b1, 1'b0, 8'hAA);
        check("ovf_pulse", 32'(bus.overflow), 32'd1);
        check("ovf_full",  32'(bus.full),     32'd1);
        step(1'b0, 1'b0, '0);
`ifdef FIFO_STICKY_ERR_EN
        check("ovf_after", 32'(bus.overflow), 32'd1);
`else
        check("ovf_after", 32'(bus.overflow), 32'd0);
`endif

        // Simultaneous read/write while full
        step(1'b1, 1'b1, 8'h55);
        check("rw_full_full", 32'(bus.full),     32'd1);
        check("rw_full_dout", 32'(bus.data_out), 32'h00);
`ifndef FIFO_STICKY_ERR_EN
        check("rw_full_novf", 32'(bus.overflow), 32'd0);
`endif
        for (int i = 0; i < c_DEPTH; i++) begin
            step(1'b0, 1'b1, '0);
            check("drain_data", 32'(bus.data_out), (i < c_DEPTH - 1) ? 32'(i + 1) : 32'h55);
        end
        check("drain_empty", 32'(bus.empty), 32'd1);

        // Underflow while empty
        step(1'b0, 1'b1, '0);
        check("unf_pulse", 32'(bus.underflow), 32'd1);
        check("unf_dout",  32'(bus.data_out),  32'h55);
        check("unf_empty", 32'(bus.empty),     32'd1);
        step(1'b0, 1'b0, '0);
`ifndef FIFO_STICKY_ERR_EN
        check("unf_after", 32'(bus.underflow), 32'd0);
`endif

        // Simultaneous read/write while empty
        step(1'b1, 1'b1, 8'h33);
        check("rw_empty_unf",   32'(bus.underflow),    32'd1);
        check("rw_empty_empty", 32'(bus.empty),        32'd0);
        check("rw_empty_ae",    32'(bus.almost_empty), 32'd1);
        check("rw_empty_dout",  32'(bus.data_out),     32'h55);
        step(1'b0, 1'b1, '0);
        check("rw_empty_read",  32'(bus.data_out),     32'h33);

        // Pointer wrap: write 10, read 10, write 12, read 12
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, c_DW'(8'h10 + i));
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, '0);
            check("wrap_a", 32'(bus.data_out), 32'(8'h10 + i));
        end
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, c_DW'(8'hC0 + i));
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, '0);
            check("wrap_b", 32'(bus.data_out), 32'(8'hC0 + i));
        end

        // Mid-operation reset
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, c_DW'(8'h70 + i));
        reset_n = 1'b0;
        step(1'b0, 1'b0, '0);
        reset_n = 1'b1;
        check("mrst_empty", 32'(bus.empty),     32'd1);
        check("mrst_dout",  32'(bus.data_out),  32'd0);
        step(1'b0, 1'b1, '0);
        check("mrst_unf",   32'(bus.underflow), 32'd1);

        // Randomized traffic with shifting write/read bias
        for (int blk = 0; blk < 20; blk++) begin
            int wp;
            int rp;
            wp = $urandom_range(10, 90);
            rp = $urandom_range(10, 90);
            for (int n = 0; n < 150; n++) begin
                reset_n = ($urandom_range(0, 299) != 0);
                step(($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < rp),
                     c_DW'($urandom));
            end
        end
        reset_n = 1'b1;
        step(1'b0, 1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_sync_fifo
`default_nettype wire
